operand_sequencer: RTL and testbench

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/opseq_pkg.sv | 15 +
 rtl/operand_sequencer.sv | 143 ++++++++++++++
 tb/tb_operand_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/opseq_pkg.sv
// Shared types and default parameters for the operand sequencer.
package opseq_pkg;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_TIMEOUT = 255;
   localparam int unsigned CNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_B = 2'd1,
      EXEC   = 2'd2,
      HOLD   = 2'd3
   } opseq_state_e;

endpackage

// File: rtl/operand_sequencer.sv
// Collects two operands, lets a downstream combinational stage compute for one
// cycle and holds the registered result until taken. Optional WAIT_B timeout: OPSEQ_TIMEOUT_EN.
module operand_sequencer
   import opseq_pkg::*;
#(
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] stage_y,
   output logic [WIDTH-1:0] res_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy,
   output logic             err
);

   if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
      $error("TIMEOUT must fit the 8-bit wait counter (1..255)");
   end

   opseq_state_e     r_state;
   opseq_state_e     w_state_nxt;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic [WIDTH-1:0] r_res_data;
   logic [WIDTH-1:0] w_op_a_nxt;
   logic [WIDTH-1:0] w_op_b_nxt;
   logic [WIDTH-1:0] w_res_nxt;
   logic             r_res_valid;
   logic             r_busy;
   logic             w_in_ready;

`ifdef OPSEQ_TIMEOUT_EN
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_err;
   logic             w_err_nxt;
`endif

   // Next-state and datapath update; everything freezes while ena is low.
   always_comb begin
      w_state_nxt = r_state;
      w_op_a_nxt  = r_op_a;
      w_op_b_nxt  = r_op_b;
      w_res_nxt   = r_res_data;
      w_in_ready  = 1'b0;
`ifdef OPSEQ_TIMEOUT_EN
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = 1'b0;
`endif
      if (ena) begin
         case (r_state)
            IDLE: begin
               w_in_ready = 1'b1;
               if (in_valid) begin
                  w_op_a_nxt  = in_data;
                  w_state_nxt = WAIT_B;
`ifdef OPSEQ_TIMEOUT_EN
                  w_cnt_nxt   = '0;
`endif
               end
            end
            WAIT_B: begin
               w_in_ready = 1'b1;
               if (in_valid) begin
                  w_op_b_nxt  = in_data;
                  w_state_nxt = EXEC;
`ifdef OPSEQ_TIMEOUT_EN
                  w_cnt_nxt   = '0;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  w_state_nxt = IDLE;
                  w_err_nxt   = 1'b1;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
`endif
               end
            end
            EXEC: begin
               w_res_nxt   = stage_y;
               w_state_nxt = HOLD;
            end
            HOLD: begin
               if (res_ready) begin
                  w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_op_a      <= '0;
         r_op_b      <= '0;
         r_res_data  <= '0;
         r_res_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_op_a      <= w_op_a_nxt;
         r_op_b      <= w_op_b_nxt;
         r_res_data  <= w_res_nxt;
         r_res_valid <= (w_state_nxt == HOLD);
         r_busy      <= (w_state_nxt != IDLE);
      end
   end

`ifdef OPSEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_err <= w_err_nxt;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   // Gated by rst_n so every output reads 0 while reset is held.
   assign in_ready  = w_in_ready & rst_n;
   assign op_a      = r_op_a;
   assign op_b      = r_op_b;
   assign res_data  = r_res_data;
   assign res_valid = r_res_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer with an adder as the downstream stage.
`timescale 1ns/1ps
module tb_operand_sequencer;
   import opseq_pkg::*;

`ifdef OPSEQ_TIMEOUT_EN
   localparam int unsigned TO    = 4;
   localparam bit          TO_ON = 1'b1;
`else
   localparam int unsigned TO    = DEF_TIMEOUT;
   localparam bit          TO_ON = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [7:0] stage_y;
   logic [7:0] res_data;
   logic       res_valid;
   logic       res_ready;
   logic       busy;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;

   operand_sequencer #(.WIDTH(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .stage_y(stage_y),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .err(err)
   );

   assign stage_y = op_a + op_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Transaction-level reference: operand pending, compute pending, result held.
   bit         m_have_a, m_exec, m_hold, m_err;
   int         m_wait;
   logic [7:0] m_a, m_b, m_res;

   task automatic model_reset();
      m_have_a = 0; m_exec = 0; m_hold = 0; m_err = 0; m_wait = 0;
      m_a = '0; m_b = '0; m_res = '0;
   endtask

   task automatic model_edge();
      m_err = 0;
      if (ena) begin
         if (m_hold) begin
            if (res_ready) m_hold = 0;
         end else if (m_exec) begin
            m_res  = 8'(m_a + m_b);
            m_exec = 0;
            m_hold = 1;
         end else if (in_valid) begin
            if (!m_have_a) begin
               m_a = in_data; m_have_a = 1; m_wait = 0;
            end else begin
               m_b = in_data; m_have_a = 0; m_exec = 1;
            end
         end else if (m_have_a && TO_ON) begin
            m_wait++;
            if (m_wait == int'(TO)) begin
               m_have_a = 0;
               m_err    = 1;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      chk("in_ready",  32'(in_ready),  32'(rst_n & ena & ~m_exec & ~m_hold));
      chk("busy",      32'(busy),      32'(m_have_a | m_exec | m_hold));
      chk("res_valid", 32'(res_valid), 32'(m_hold));
      chk("res_data",  32'(res_data),  32'(m_res));
      chk("op_a",      32'(op_a),      32'(m_a));
      chk("op_b",      32'(op_b),      32'(m_b));
      chk("err",       32'(err),       32'(m_err));
   endtask

   task automatic cycle(input logic e, input logic v, input logic [7:0] d, input logic rr);
      ena = e; in_valid = v; in_data = d; res_ready = rr;
      @(posedge clk);
      model_edge();
      #1;
      cmp_model();
   endtask

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       rr;
      logic       exp_rdy;
      logic       exp_busy;
      logic       exp_rv;
      logic [7:0] exp_a;
      logic [7:0] exp_b;
      logic [7:0] exp_res;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // Directed arithmetic vectors: 0x12+0x34 and the wrapping 0xF0+0x20.
      tbl[0] = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h00, 8'h00};
      tbl[1] = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'h00};
      tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 8'h46};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h46};
      tbl[4] = '{1'b1, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 8'h34, 8'h46};
      tbl[5] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h20, 8'h46};
      tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF0, 8'h20, 8'h10};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hF0, 8'h20, 8'h10};

      rst_n = 1'b0; ena = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
      model_reset();
      #7;
      chk("rst_busy",      32'(busy),      32'(0));
      chk("rst_res_valid", 32'(res_valid), 32'(0));
      chk("rst_op_a",      32'(op_a),      32'(0));
      chk("rst_res_data",  32'(res_data),  32'(0));
      chk("rst_in_ready",  32'(in_ready),  32'(0));
      #5;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, tbl[i].v, tbl[i].d, tbl[i].rr);
         chk("tbl_in_ready", 32'(in_ready),  32'(tbl[i].exp_rdy));
         chk("tbl_busy",     32'(busy),      32'(tbl[i].exp_busy));
         chk("tbl_res_valid",32'(res_valid), 32'(tbl[i].exp_rv));
         chk("tbl_op_a",     32'(op_a),      32'(tbl[i].exp_a));
         chk("tbl_op_b",     32'(op_b),      32'(tbl[i].exp_b));
         chk("tbl_res_data", 32'(res_data),  32'(tbl[i].exp_res));
      end

      // Result held for 10 cycles while new bytes are offered and refused.
      cycle(1'b1, 1'b1, 8'h0A, 1'b0);
      cycle(1'b1, 1'b1, 8'h0B, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
         chk("hold_res_data", 32'(res_data),  32'(8'h15));
         chk("hold_in_ready", 32'(in_ready),  32'(0));
         chk("hold_res_valid",32'(res_valid), 32'(1));
         chk("hold_op_a",     32'(op_a),      32'(8'h0A));
         chk("hold_op_b",     32'(op_b),      32'(8'h0B));
      end
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      chk("hold_release_busy", 32'(busy), 32'(0));

      // ena low in WAIT_B freezes everything and refuses data.
      cycle(1'b1, 1'b1, 8'h31, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b1, 8'h99, 1'b0);
         chk("ena_in_ready", 32'(in_ready), 32'(0));
         chk("ena_busy",     32'(busy),     32'(1));
         chk("ena_op_a",     32'(op_a),     32'(8'h31));
         chk("ena_op_b",     32'(op_b),     32'(8'h0B));
      end
      cycle(1'b1, 1'b1, 8'h42, 1'b0);
      chk("ena_resume_op_b", 32'(op_b), 32'(8'h42));
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      chk("ena_resume_res", 32'(res_data), 32'(8'h73));
      cycle(1'b1, 1'b0, 8'h00, 1'b1);

      if (TO_ON) begin
         cycle(1'b1, 1'b1, 8'h66, 1'b0);
         for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0);
            chk("to_err_early", 32'(err),  32'(0));
            chk("to_busy",      32'(busy), 32'(1));
         end
         cycle(1'b1, 1'b0, 8'h00, 1'b0);
         chk("to_err_pulse", 32'(err),      32'(1));
         chk("to_idle",      32'(busy),     32'(0));
         chk("to_in_ready",  32'(in_ready), 32'(1));
         cycle(1'b1, 1'b0, 8'h00, 1'b0);
         chk("to_err_once",  32'(err),      32'(0));
      end

      // Asynchronous reset in the middle of a WAIT_B cycle.
      cycle(1'b1, 1'b1, 8'hC3, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",      32'(busy),      32'(0));
      chk("arst_op_a",      32'(op_a),      32'(0));
      chk("arst_op_b",      32'(op_b),      32'(0));
      chk("arst_res_data",  32'(res_data),  32'(0));
      chk("arst_res_valid", 32'(res_valid), 32'(0));
      chk("arst_err",       32'(err),       32'(0));
      chk("arst_in_ready",  32'(in_ready),  32'(0));
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
      cycle(1'b1, 1'b1, 8'h5A, 1'b0);
      chk("arst_next_is_a", 32'(op_a), 32'(8'h5A));
      chk("arst_next_op_b", 32'(op_b), 32'(0));

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
               8'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
